// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between the fetch/resolve side and branch_resolve_queue,
// including the registered update strobe that feeds the 2-bit predictor.
interface branch_resolve_queue_if;
    logic pred_valid;
    logic pred_bit;
    logic pred_ready;
    logic res_valid;
    logic res_taken;
    logic res_ready;
    logic upd_request;
    logic upd_taken;
    logic mispredict;

    modport master (
        output pred_valid, pred_bit, res_valid, res_taken,
        input  pred_ready, res_ready, upd_request, upd_taken, mispredict
    );

    modport slave (
        input  pred_valid, pred_bit, res_valid, res_taken,
        output pred_ready, res_ready, upd_request, upd_taken, mispredict
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order prediction/outcome pairing queue driving predictor training updates.
// Optional macro BRQ_FLUSH_EN adds a 'flush' input that empties the queue.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef BRQ_FLUSH_EN
    input  logic                         flush,
`endif
    branch_resolve_queue_if.slave        bus,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             total_count,
    output logic [CNT_W-1:0]             miss_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             clear;
    logic             push;
    logic             pop;
    logic             head_miss;

`ifdef BRQ_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    // Ready flags come only from registered occupancy, so a push into an
    // empty queue cannot be popped and a full queue refuses even while popping.
    assign full           = (occupancy == FULL_LEVEL);
    assign empty          = (occupancy == '0);
    assign bus.pred_ready = !full;
    assign bus.res_ready  = !empty;
    assign push           = bus.pred_valid && !full && !clear;
    assign pop            = bus.res_valid && !empty && !clear;
    assign head_miss      = (mem[rd_ptr] != bus.res_taken);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.pred_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    // Flush suppresses pop, so counters and upd_taken simply hold through it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.upd_request <= 1'b0;
            bus.upd_taken   <= 1'b0;
            bus.mispredict  <= 1'b0;
            total_count     <= '0;
            miss_count      <= '0;
        end else begin
            bus.upd_request <= pop;
            bus.mispredict  <= pop && head_miss;
            if (pop) begin
                bus.upd_taken <= bus.res_taken;
                if (total_count != '1) begin
                    total_count <= total_count + 1'b1;
                end
                if (head_miss && (miss_count != '1)) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized self-checking bench for branch_resolve_queue with a queue-based
// reference model, plus a small CNT_W=3 instance for saturation.
module tb_branch_resolve_queue;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_queue_if bus_m();
    branch_resolve_queue_if bus_s();

    logic        full, empty;
    logic [3:0]  occupancy;
    logic [15:0] total_count, miss_count;
    logic        s_full, s_empty;
    logic [2:0]  s_occupancy;
    logic [2:0]  s_total, s_miss;

    branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
`ifdef BRQ_FLUSH_EN
        .flush(flush),
`endif
        .bus(bus_m),
        .full(full),
        .empty(empty),
        .occupancy(occupancy),
        .total_count(total_count),
        .miss_count(miss_count)
    );

    branch_resolve_queue #(.DEPTH(4), .CNT_W(3)) dut_sat (
        .clk(clk),
        .rst(rst),
`ifdef BRQ_FLUSH_EN
        .flush(1'b0),
`endif
        .bus(bus_s),
        .full(s_full),
        .empty(s_empty),
        .occupancy(s_occupancy),
        .total_count(s_total),
        .miss_count(s_miss)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs expected after each edge, from queue semantics.
    bit model_q[$];
    bit exp_req = 1'b0, exp_taken = 1'b0, exp_mis = 1'b0;
    int exp_total = 0, exp_miss = 0;

    always @(posedge clk) begin : model
        bit do_push, do_pop, head;
        if (rst) begin
            model_q.delete();
            exp_req = 0; exp_taken = 0; exp_mis = 0;
            exp_total = 0; exp_miss = 0;
        end else if (flush) begin
            model_q.delete();
            exp_req = 0; exp_mis = 0;
        end else begin
            do_pop  = bus_m.res_valid && (model_q.size() > 0);
            do_push = bus_m.pred_valid && (model_q.size() < DEPTH);
            exp_req = do_pop;
            exp_mis = 0;
            if (do_pop) begin
                head      = model_q.pop_front();
                exp_taken = bus_m.res_taken;
                exp_mis   = (head != bus_m.res_taken);
                if (exp_total < CNT_MAX) exp_total++;
                if (exp_mis && exp_miss < CNT_MAX) exp_miss++;
            end
            if (do_push) model_q.push_back(bus_m.pred_bit);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("occupancy", occupancy, model_q.size());
            check_output("empty", empty, model_q.size() == 0);
            check_output("full", full, model_q.size() == DEPTH);
            check_output("pred_ready", bus_m.pred_ready, model_q.size() != DEPTH);
            check_output("res_ready", bus_m.res_ready, model_q.size() != 0);
            check_output("upd_request", bus_m.upd_request, exp_req);
            check_output("upd_taken", bus_m.upd_taken, exp_taken);
            check_output("mispredict", bus_m.mispredict, exp_mis);
            check_output("total_count", total_count, exp_total);
            check_output("miss_count", miss_count, exp_miss);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit pv, input bit pb, input bit rv, input bit rt);
        bus_m.pred_valid = pv;
        bus_m.pred_bit   = pb;
        bus_m.res_valid  = rv;
        bus_m.res_taken  = rt;
        tick();
    endtask

    logic [7:0] bits;
    int total_before;

    initial begin
        bus_m.pred_valid = 0; bus_m.pred_bit = 0; bus_m.res_valid = 0; bus_m.res_taken = 0;
        bus_s.pred_valid = 0; bus_s.pred_bit = 0; bus_s.res_valid = 0; bus_s.res_taken = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        checking = 1;
        check_output("reset_empty", empty, 1);
        check_output("reset_full", full, 0);
        check_output("reset_pred_ready", bus_m.pred_ready, 1);
        check_output("reset_res_ready", bus_m.res_ready, 0);
        check_output("reset_total", total_count, 0);

        // Push 1,0,1 then resolve all taken: only the middle one mispredicts.
        apply_stimulus(1, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0);
        check_output("t1_occupancy", occupancy, 3);
        check_output("t1_res_ready", bus_m.res_ready, 1);
        apply_stimulus(0, 0, 1, 1);
        check_output("t1_req0", bus_m.upd_request, 1);
        check_output("t1_mis0", bus_m.mispredict, 0);
        apply_stimulus(0, 0, 1, 1);
        check_output("t1_mis1", bus_m.mispredict, 1);
        apply_stimulus(0, 0, 1, 1);
        check_output("t1_mis2", bus_m.mispredict, 0);
        check_output("t1_taken", bus_m.upd_taken, 1);
        apply_stimulus(0, 0, 0, 0);
        check_output("t1_req_idle", bus_m.upd_request, 0);
        check_output("t1_total", total_count, 3);
        check_output("t1_miss", miss_count, 1);

        // Fill to capacity, attempt a 9th push, then drain in order.
        bits = 8'($urandom);
        for (int i = 0; i < 8; i++) apply_stimulus(1, bits[i], 0, 0);
        check_output("t2_full", full, 1);
        check_output("t2_pred_ready", bus_m.pred_ready, 0);
        apply_stimulus(1, ~bits[0], 0, 0);
        check_output("t2_occ_after_9th", occupancy, 8);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 1, 0);
            check_output("t2_order", bus_m.mispredict, bits[i]);
        end
        check_output("t2_empty", empty, 1);

        // Steady push+pop at level 4 wraps both pointers.
        for (int i = 0; i < 4; i++) apply_stimulus(1, 1'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 1'($urandom), 1, 1'($urandom));
            check_output("t3_occupancy", occupancy, 4);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 1'($urandom));

        // No pop while empty, and no bypass of a fresh push.
        apply_stimulus(0, 0, 1, 1);
        check_output("t4_no_req_empty", bus_m.upd_request, 0);
        apply_stimulus(1, 1, 1, 0);
        check_output("t4_no_bypass", bus_m.upd_request, 0);
        check_output("t4_occ", occupancy, 1);
        apply_stimulus(0, 0, 1, 0);
        check_output("t4_pop_next", bus_m.upd_request, 1);
        check_output("t4_mis", bus_m.mispredict, 1);

        // Saturating counters on the CNT_W=3 instance.
        for (int i = 0; i < 9; i++) begin
            bus_s.pred_valid = 1; bus_s.pred_bit = 1; bus_s.res_valid = 0;
            tick();
            bus_s.pred_valid = 0; bus_s.res_valid = 1; bus_s.res_taken = 0;
            tick();
        end
        bus_s.res_valid = 0;
        tick();
        check_output("t5_sat_total", s_total, 7);
        check_output("t5_sat_miss", s_miss, 7);
        check_output("t5_sat_empty", s_empty, 1);

`ifdef BRQ_FLUSH_EN
        for (int i = 0; i < 5; i++) apply_stimulus(1, 1'($urandom), 0, 0);
        total_before = exp_total;
        flush = 1;
        apply_stimulus(0, 0, 1, 1);
        flush = 0;
        check_output("t6_flush_occ", occupancy, 0);
        check_output("t6_flush_req", bus_m.upd_request, 0);
        check_output("t6_flush_total", total_count, total_before);
`endif

        // Reset with entries queued discards them and clears counters.
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 0);
        rst = 1;
        apply_stimulus(1, 1, 1, 1);
        rst = 0;
        check_output("t7_rst_occ", occupancy, 0);
        check_output("t7_rst_total", total_count, 0);
        check_output("t7_rst_miss", miss_count, 0);
        check_output("t7_rst_taken", bus_m.upd_taken, 0);
        check_output("t7_rst_req", bus_m.upd_request, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
`ifdef BRQ_FLUSH_EN
            flush = ($urandom_range(0, 99) == 0);
`endif
            apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst = 0;
        flush = 0;
        apply_stimulus(0, 0, 0, 0);
        checking = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
